mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 48 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional round-robin policy is selected with MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 9;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way winner select. With MEM_ARB_ROUND_ROBIN_EN defined, ties go to the
// port not granted last; otherwise port B always wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic a_req,
  input  logic b_req,
  input  logic grant_en,
  output logic grant_valid,
  output logic grant_port
);

  assign grant_valid = grant_en & (a_req | b_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;
  logic last_d;

  always_comb begin
    grant_port = PORT_A;
    last_d     = last_q;
    if (a_req && b_req) begin
      grant_port = ~last_q;
    end else if (b_req) begin
      grant_port = PORT_B;
    end
    if (grant_valid) begin
      last_d = grant_port;
    end
  end

  // Reset value "last granted B" makes A win the first tie.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      last_q <= PORT_B;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = clk ^ clr;
  assign grant_port  = b_req ? PORT_B : PORT_A;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) arbiter onto a single-port registered-read RAM.
// Tie policy is set by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_enable,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  port_q, port_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  grant_valid;
  logic                  grant_port;

  mem_arb_pick u_pick (
    .clk         (clk),
    .clr         (clr),
    .a_req       (a_req),
    .b_req       (b_req),
    .grant_en    (state_q == ST_IDLE),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    port_d    = port_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          port_d  = grant_port;
          we_d    = (grant_port == PORT_B) ? b_we    : a_we;
          addr_d  = (grant_port == PORT_B) ? b_addr  : a_addr;
          wdata_d = (grant_port == PORT_B) ? b_wdata : a_wdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = we_q ? ST_ACK : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // RAM read data is registered, so it is valid one cycle after ISSUE.
        if (port_q == PORT_B) begin
          b_rdata_d = ram_data_out;
        end else begin
          a_rdata_d = ram_data_out;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      port_q    <= PORT_A;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      port_q    <= port_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign ram_enable  = (state_q == ST_ISSUE);
  assign ram_read    = ram_enable & ~we_q;
  assign ram_write   = ram_enable & we_q;
  assign ram_address = addr_q;
  assign ram_data_in = wdata_q;
  assign a_ack       = (state_q == ST_ACK) && (port_q == PORT_A);
  assign b_ack       = (state_q == ST_ACK) && (port_q == PORT_B);
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (reference memory, per-port rdata, tie policy).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [8:0]  a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [8:0]  b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic        a_ack, b_ack;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_enable, ram_read, ram_write;
  logic [8:0]  ram_address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out = '0;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ram_mem [512];
  logic [31:0] ref_mem [512];
  logic [31:0] exp_rd  [2];
  logic        last_grant;

  mem_arbiter dut (
    .clk(clk), .clr(clr),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_enable(ram_enable), .ram_read(ram_read), .ram_write(ram_write),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Registered-read RAM model.
  always @(posedge clk) begin
    if (ram_enable && ram_write) ram_mem[ram_address] <= ram_data_in;
    if (ram_enable && ram_read)  ram_data_out <= ram_mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic p, input logic we, input logic [8:0] addr, input logic [31:0] data);
    if (p) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
    end
  endtask

  function automatic logic tie_winner();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return ~last_grant;
`else
    return 1'b1;
`endif
  endfunction

  // Follows one granted transaction from its sampling edge to its ack cycle.
  task automatic wait_txn(input logic p, input logic we, input logic [8:0] addr,
                          input logic [31:0] data, input bit drop);
    int lat;
    lat = we ? 2 : 3;
    if (we) ref_mem[addr] = data;
    else    exp_rd[p] = ref_mem[addr];
    last_grant = p;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); @(negedge clk);
      check("busy", busy, 1'b1);
      check("ram_enable", ram_enable, c == 1);
      check("ram_read", ram_read, (c == 1) && !we);
      check("ram_write", ram_write, (c == 1) && we);
      if (c == 1) begin
        check("ram_address", ram_address, addr);
        if (we) check("ram_data_in", ram_data_in, data);
      end
      check("a_ack", a_ack, (c == lat) && (p == 1'b0));
      check("b_ack", b_ack, (c == lat) && (p == 1'b1));
    end
    check("a_rdata", a_rdata, exp_rd[0]);
    check("b_rdata", b_rdata, exp_rd[1]);
    if (drop) begin
      if (p) b_req = 1'b0; else a_req = 1'b0;
    end
  endtask

  task automatic idle_check();
    @(posedge clk); @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_ram_enable", ram_enable, 1'b0);
    check("idle_acks", {a_ack, b_ack}, 2'b00);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 512; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last_grant = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_acks", {a_ack, b_ack}, 2'b00);
    check("rst_strobes", {ram_enable, ram_read, ram_write}, 3'b000);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    clr = 1'b0;
    idle_check();

    // Port A write then read back.
    drive(1'b0, 1'b1, 9'h0AB, 32'hDEADBEEF);
    wait_txn(1'b0, 1'b1, 9'h0AB, 32'hDEADBEEF, 1'b1);
    idle_check();
    drive(1'b0, 1'b0, 9'h0AB, 32'h0);
    wait_txn(1'b0, 1'b0, 9'h0AB, 32'h0, 1'b1);
    check("a_read_0ab", a_rdata, 32'hDEADBEEF);
    idle_check();

    // Port B write to top address, port A read back; B rdata stays 0.
    drive(1'b1, 1'b1, 9'h1FF, 32'h12345678);
    wait_txn(1'b1, 1'b1, 9'h1FF, 32'h12345678, 1'b1);
    idle_check();
    drive(1'b0, 1'b0, 9'h1FF, 32'h0);
    wait_txn(1'b0, 1'b0, 9'h1FF, 32'h0, 1'b1);
    check("a_read_1ff", a_rdata, 32'h12345678);
    check("b_rdata_untouched", b_rdata, 32'h0);
    idle_check();

    // Simultaneous reads: winner by policy, loser one idle cycle after ack.
    begin
      logic w;
      w = tie_winner();
      drive(1'b0, 1'b0, 9'h0AB, 32'h0);
      drive(1'b1, 1'b0, 9'h1FF, 32'h0);
      wait_txn(w, 1'b0, w ? 9'h1FF : 9'h0AB, 32'h0, 1'b1);
      idle_check();
      wait_txn(~w, 1'b0, w ? 9'h0AB : 9'h1FF, 32'h0, 1'b1);
      idle_check();
    end

    // Port A held high across three transactions.
    drive(1'b0, 1'b1, 9'h010, 32'hA5A5_0001);
    wait_txn(1'b0, 1'b1, 9'h010, 32'hA5A5_0001, 1'b0);
    a_we = 1'b0;
    idle_check();
    wait_txn(1'b0, 1'b0, 9'h010, 32'h0, 1'b0);
    a_we = 1'b1; a_addr = 9'h011; a_wdata = 32'hA5A5_0002;
    idle_check();
    wait_txn(1'b0, 1'b1, 9'h011, 32'hA5A5_0002, 1'b1);
    idle_check();

    // Reset during CAPTURE of a port A read aborts it.
    drive(1'b0, 1'b0, 9'h011, 32'h0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_busy", busy, 1'b0);
    check("clr_a_ack", a_ack, 1'b0);
    check("clr_a_rdata", a_rdata, 32'h0);
    check("clr_strobes", {ram_enable, ram_read, ram_write}, 3'b000);
    a_req = 1'b0;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last_grant = 1'b1;
    repeat (3) idle_check();
    drive(1'b0, 1'b0, 9'h011, 32'h0);
    wait_txn(1'b0, 1'b0, 9'h011, 32'h0, 1'b1);
    check("post_clr_read", a_rdata, 32'hA5A5_0002);
    idle_check();

    // Randomized single and simultaneous traffic.
    for (int n = 0; n < 40; n++) begin
      logic        pa_we, pb_we, w, p;
      logic [8:0]  pa_addr, pb_addr;
      logic [31:0] pa_data, pb_data;
      pa_we = 1'($urandom_range(0, 1));
      pb_we = 1'($urandom_range(0, 1));
      pa_addr = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
      pb_addr = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
      pa_data = $urandom;
      pb_data = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        w = tie_winner();
        drive(1'b0, pa_we, pa_addr, pa_data);
        drive(1'b1, pb_we, pb_addr, pb_data);
        if (w) wait_txn(1'b1, pb_we, pb_addr, pb_data, 1'b1);
        else   wait_txn(1'b0, pa_we, pa_addr, pa_data, 1'b1);
        idle_check();
        if (w) wait_txn(1'b0, pa_we, pa_addr, pa_data, 1'b1);
        else   wait_txn(1'b1, pb_we, pb_addr, pb_data, 1'b1);
      end else begin
        p = 1'($urandom_range(0, 1));
        if (p) begin
          drive(1'b1, pb_we, pb_addr, pb_data);
          wait_txn(1'b1, pb_we, pb_addr, pb_data, 1'b1);
        end else begin
          drive(1'b0, pa_we, pa_addr, pa_data);
          wait_txn(1'b0, pa_we, pa_addr, pa_data, 1'b1);
        end
      end
      idle_check();
      repeat ($urandom_range(0, 2)) idle_check();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
